// File: rtl/r5p_gpr.sv
// r5p_gpr -- RISC-V general purpose register file.
//
// Two combinational read ports and one write port. Reads of address 0
// always return 0, and writes to address 0 are dropped. A write is
// forwarded to any read port that addresses the same register in the
// same cycle.
//
// Optional feature macro: R5P_GPR_CLEAR_EN
//   defined   : after reset a CLR/RUN sequencer zeroes registers
//               1..2**AW-1, one per cycle, then raises rdy.
//   undefined : no sequencer. The array has no reset, so its contents
//               are undefined after reset. rdy rises on the first clk
//               edge after rst is released.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset
//   rdy      out  file ready for reads and writes
//   a1/d1    in/out  read port 1 address (rs1) / data
//   a2/d2    in/out  read port 2 address (rs2) / data
//   we       in   write enable (rd writeback)
//   wa/wd    in   write address / write data
module r5p_gpr #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  output logic            rdy,
  input  logic [AW-1:0]   a1,
  output logic [XLEN-1:0] d1,
  input  logic [AW-1:0]   a2,
  output logic [XLEN-1:0] d2,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd
);

  localparam int NREG = 2**AW - 1;

  // Address 0 is hard-wired to zero, so it is not part of the storage array.
  logic [XLEN-1:0] r_mem [1:NREG];

  logic w_rdy;
  logic w_wr;

  assign w_wr = we & w_rdy & (wa != '0);

`ifdef R5P_GPR_CLEAR_EN
  // state | meaning
  // S_CLR | zeroing register r_cnt this cycle, rdy=0
  // S_RUN | normal operation, rdy=1
  typedef enum logic {S_CLR = 1'b0, S_RUN = 1'b1} state_t;

  localparam logic [AW-1:0] LAST = AW'(NREG);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_cnt;
  logic          w_clr;

  // The counter holds at LAST instead of wrapping to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_CLR;
      r_cnt   <= AW'(1);
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_CLR && r_cnt != LAST) r_cnt <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == S_CLR && r_cnt == LAST) w_state_nxt = S_RUN;
  end

  always_comb begin
    w_rdy = (r_state == S_RUN);
    w_clr = (r_state == S_CLR) & ~rst;
  end

  // w_wr is always 0 in S_CLR, so the two write sources never collide.
  always_ff @(posedge clk) begin
    if (w_wr)       r_mem[wa]    <= wd;
    else if (w_clr) r_mem[r_cnt] <= '0;
  end
`else
  logic r_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rdy <= 1'b0;
    else     r_rdy <= 1'b1;
  end

  assign w_rdy = r_rdy;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[wa] <= wd;
  end
`endif

  assign rdy = w_rdy;

  // Priority: not ready or x0 -> 0; same-cycle write -> bypass; else array.
  assign d1 = (!w_rdy || a1 == '0)  ? '0 :
              (w_wr && wa == a1)    ? wd : r_mem[a1];
  assign d2 = (!w_rdy || a2 == '0)  ? '0 :
              (w_wr && wa == a2)    ? wd : r_mem[a2];

endmodule

// File: tb/tb_r5p_gpr.sv
// Bench for r5p_gpr. It drives one stimulus stream into two instances,
// one with AW=5 and one with AW=4. A reference model of each register
// file is checked against the DUTs on every negative clock edge.
module tb_r5p_gpr;

`ifdef R5P_GPR_CLEAR_EN
  localparam int  LAT5  = 31;
  localparam int  LAT4  = 15;
  localparam bit  CLEAR = 1'b1;
`else
  localparam int  LAT5  = 1;
  localparam int  LAT4  = 1;
  localparam bit  CLEAR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we  = 1'b0;
  logic [4:0]  a1  = '0;
  logic [4:0]  a2  = '0;
  logic [4:0]  wa  = '0;
  logic [31:0] wd  = '0;

  logic        rdy5, rdy4;
  logic [31:0] d1_5, d2_5, d1_4, d2_4;

  int n_chk  = 0;
  int n_fail = 0;
  bit run_chk = 1'b0;

  always #5 clk = ~clk;

  r5p_gpr #(.XLEN(32), .AW(5)) u_gpr5 (
    .clk(clk), .rst(rst), .rdy(rdy5),
    .a1(a1), .d1(d1_5), .a2(a2), .d2(d2_5),
    .we(we), .wa(wa), .wd(wd)
  );

  r5p_gpr #(.XLEN(32), .AW(4)) u_gpr4 (
    .clk(clk), .rst(rst), .rdy(rdy4),
    .a1(a1[3:0]), .d1(d1_4), .a2(a2[3:0]), .d2(d2_4),
    .we(we), .wa(wa[3:0]), .wd(wd)
  );

  // Reference model: register values, whether each value is defined,
  // and the number of clock edges seen since reset was released.
  logic [31:0] m_mem   [2][32];
  bit          m_known [2][32];
  int          m_rel   [2];

  function automatic int lat(input int i);
    return (i == 0) ? LAT5 : LAT4;
  endfunction

  function automatic logic [4:0] msk(input int i, input logic [4:0] a);
    return (i == 0) ? a : {1'b0, a[3:0]};
  endfunction

  function automatic bit m_rdy(input int i);
    return !rst && (m_rel[i] >= lat(i));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_rd(input int i, input string nm, input logic [4:0] a,
                        input logic [31:0] act);
    logic [4:0] ma;
    logic [4:0] mw;
    ma = msk(i, a);
    mw = msk(i, wa);
    if (!m_rdy(i) || ma == 5'd0)           chk(nm, act, 32'h0);
    else if (we && mw != 5'd0 && mw == ma) chk(nm, act, wd);
    else if (m_known[i][ma])               chk(nm, act, m_mem[i][ma]);
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_rel[i] = 0;
        for (int j = 0; j < 32; j++) begin
          m_mem[i][j]   = 32'h0;
          m_known[i][j] = CLEAR;
        end
      end else begin
        if (m_rdy(i) && we && msk(i, wa) != 5'd0) begin
          m_mem[i][msk(i, wa)]   = wd;
          m_known[i][msk(i, wa)] = 1'b1;
        end
        if (m_rel[i] < 1000) m_rel[i]++;
      end
    end
  end

  always @(negedge clk) begin
    if (run_chk) begin
      chk("rdy_aw5", {31'b0, rdy5}, {31'b0, m_rdy(0)});
      chk("rdy_aw4", {31'b0, rdy4}, {31'b0, m_rdy(1)});
      chk_rd(0, "d1_aw5", a1, d1_5);
      chk_rd(0, "d2_aw5", a2, d2_5);
      chk_rd(1, "d1_aw4", a1, d1_4);
      chk_rd(1, "d2_aw4", a2, d2_4);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rdy(input string nm, input logic drive_we);
    int n;
    n = 0;
    we = drive_we; wa = 5'd3; wd = 32'hFFFF_FFFF;
    while (rdy5 !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    we = 1'b0;
    chk(nm, 32'(n), 32'(LAT5));
  endtask

  initial begin
    #1;
    run_chk = 1'b1;

    // A write attempted while rst is held must be dropped and all outputs held at 0.
    we = 1'b1; wa = 5'd5; wd = 32'h1111_1111; a1 = 5'd5; a2 = 5'd5;
    @(negedge clk);
    chk("rst_rdy", {31'b0, rdy5}, 32'h0);
    chk("rst_d1", d1_5, 32'h0);
    tick(); tick();
    we = 1'b0;
    rst = 1'b0;
    wait_rdy("rdy_latency", 1'b1);

`ifdef R5P_GPR_CLEAR_EN
    for (int a = 1; a < 32; a++) begin
      a1 = 5'(a); a2 = 5'(a);
      @(negedge clk);
      chk("cleared_d1", d1_5, 32'h0);
    end
    tick();
`endif

    // A write to x0 must never become visible.
    we = 1'b1; wa = 5'd0; wd = 32'hDEAD_BEEF; a1 = 5'd0; a2 = 5'd0;
    @(negedge clk);
    chk("x0_same", d1_5, 32'h0);
    tick();
    we = 1'b0;
    @(negedge clk);
    chk("x0_after", d1_5, 32'h0);
    tick();

    we = 1'b1; wa = 5'd3; wd = 32'h3333_3333;
    tick();
    we = 1'b1; wa = 5'd5; wd = 32'h1234_5678;
    tick();
    we = 1'b0; a1 = 5'd5; a2 = 5'd5;
    @(negedge clk);
    chk("wr_rd_d1", d1_5, 32'h1234_5678);
    chk("wr_rd_d2", d2_5, 32'h1234_5678);
    tick();

    // Same-cycle bypass on port 1 only, then on both ports together.
    we = 1'b1; wa = 5'd7; wd = 32'hA5A5_A5A5; a1 = 5'd7; a2 = 5'd3;
    @(negedge clk);
    chk("byp_d1", d1_5, 32'hA5A5_A5A5);
    chk("byp_d2_old", d2_5, 32'h3333_3333);
    a2 = 5'd7;
    @(negedge clk);
    chk("byp_both_d2", d2_5, 32'hA5A5_A5A5);
    tick();
    we = 1'b0;
    @(negedge clk);
    chk("byp_commit", d1_5, 32'hA5A5_A5A5);
    chk("aw4_commit", d1_4, 32'hA5A5_A5A5);
    tick();

    // Reset while the clear sequence is running; the sequence must restart.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    a1 = 5'd5;
    @(negedge clk);
    chk("rst2_d1", d1_5, 32'h0);
    tick();
    rst = 1'b0;
    wait_rdy("rdy_latency2", 1'b0);
    tick();

    for (int c = 0; c < 10000; c++) begin
      we = 1'($urandom_range(0, 1));
      wa = 5'($urandom_range(0, 31));
      wd = $urandom;
      a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) a2 = a1;
      tick();
    end

    run_chk = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
